// File: rtl/nios2_c_key_ctrl.sv
// ---------------------------------------------------------------------------
// nios2_c_key_ctrl
//
// Avalon-MM slave input controller for push-keys and switches on the Nios II
// system bus. Each input bit is synchronised, debounced, and checked for
// selectable rising and falling edges. Captured edges are held in a sticky
// write-1-to-clear register and raise a masked level interrupt.
//
// Register map (word addresses):
//   0 DATA     (RO)   [WIDTH-1:0] debounced state
//   1 EDGE_CFG (RW)   [WIDTH-1:0] rise_en, [16+WIDTH-1:16] fall_en
//   2 IRQ_MASK (RW)   [WIDTH-1:0]
//   3 EDGE_CAP (W1C)  [WIDTH-1:0]
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word select
//   chipselect  slave select
//   write_n     active-low write strobe (qualified by chipselect)
//   writedata   write data
//   in_port     raw asynchronous inputs
//   readdata    registered read data, one cycle latency, no wait states
//   irq         level interrupt, |(edge_cap & irq_mask)
// ---------------------------------------------------------------------------
module nios2_c_key_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_next;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [31:0]      rd_word;
    logic             wr_en;

    // Only the low WIDTH bits of each field are meaningful; the rest of the
    // write bus is deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // Debounce: the counter only runs while the synchronised input disagrees
    // with the debounced state. Any agreement restarts it from zero, so the
    // state flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        deb_next = deb;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync_q2[i] != deb[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    deb_next[i] = sync_q2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edges are detected on the same edge that the debounced state moves, and
    // use the edge-enable configuration as it stood before that edge.
    assign edge_set = (deb_next & ~deb & rise_en) | (~deb_next & deb & fall_en);
    assign edge_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Read mux; unused bits read as zero.
    always_comb begin
        rd_word = '0;
        case (address)
            2'd0: rd_word[WIDTH-1:0] = deb;
            2'd1: begin
                rd_word[WIDTH-1:0]  = rise_en;
                rd_word[16 +: WIDTH] = fall_en;
            end
            2'd2:    rd_word[WIDTH-1:0] = irq_mask;
            default: rd_word[WIDTH-1:0] = edge_cap;
        endcase
    end

    // All state. Setting an edge bit takes priority over a simultaneous
    // W1C clear so that an edge arriving during a clear is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            deb      <= '0;
            rise_en  <= '1;
            fall_en  <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_q1  <= in_port;
            sync_q2  <= sync_q1;
            deb      <= deb_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            readdata <= rd_word;
            if (wr_en && address == 2'd1) begin
                rise_en <= writedata[WIDTH-1:0];
                fall_en <= writedata[16 +: WIDTH];
            end
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios2_c_key_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nios2_c_key_ctrl
//
// Self-checking bench for nios2_c_key_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4.
// Register reads push their expected value onto a scoreboard queue; a monitor
// pops and compares once the registered read data is available. Direct irq
// and in-reset observations go through the same checking task.
// ---------------------------------------------------------------------------
module tb_nios2_c_key_ctrl;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    logic read_active;
    int   assert_count;
    int   fail_count;

    nios2_c_key_ctrl #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read data registered at the posedge following a read request is
    // compared against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        if (read_active) begin
            #1;
            if (exp_q.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput(e.tag, readdata, e.exp);
            end
        end
    end

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Bus write; called at a negedge, the write lands on the next posedge.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // Bus read; the register value sampled at the next posedge is expected.
    task automatic readReg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
        address     = a;
        read_active = 1'b1;
        @(negedge clk);
        read_active = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        assert_count = 0;
        fail_count   = 0;
        read_active  = 1'b0;
        reset_n      = 1'b0;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = '0;
        in_port      = '0;

        waitCycles(3);
        checkOutput("rst_readdata", readdata, 32'h0);
        checkOutput("rst_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        waitCycles(1);

        // Reset values of every register
        readReg("rst_data", 2'd0, 32'h0);
        readReg("rst_cfg", 2'd1, 32'h0000_000F);
        readReg("rst_mask", 2'd2, 32'h0);
        readReg("rst_cap", 2'd3, 32'h0);

        // 1: rising edge on bit0, exact debounce latency
        in_port = 4'h1;
        waitCycles(5);
        readReg("t1_deb_before", 2'd0, 32'h0);
        readReg("t1_deb_after", 2'd0, 32'h1);
        readReg("t1_cap", 2'd3, 32'h1);
        checkOutput("t1_irq", {31'd0, irq}, 32'h0);
        applyStimulus(2'd0, 32'hF);
        readReg("t1_data_ro", 2'd0, 32'h1);

        // 2: glitch of 3 cycles on bit1 is rejected, a held level is not
        in_port = 4'h3;
        waitCycles(3);
        in_port = 4'h1;
        waitCycles(10);
        readReg("t2_glitch_data", 2'd0, 32'h1);
        readReg("t2_glitch_cap", 2'd3, 32'h1);
        checkOutput("t2_glitch_irq", {31'd0, irq}, 32'h0);
        in_port = 4'h3;
        waitCycles(10);
        readReg("t2_hold_data", 2'd0, 32'h3);
        readReg("t2_hold_cap", 2'd3, 32'h3);

        // 3: mask, interrupt, W1C
        applyStimulus(2'd3, 32'h3);
        readReg("t3_cap_clr", 2'd3, 32'h0);
        applyStimulus(2'd2, 32'h2);
        checkOutput("t3_irq_idle", {31'd0, irq}, 32'h0);
        in_port = 4'h1;
        waitCycles(10);
        readReg("t3_fall_nocap", 2'd3, 32'h0);
        in_port = 4'h3;
        waitCycles(10);
        checkOutput("t3_irq_set", {31'd0, irq}, 32'h1);
        readReg("t3_cap_set", 2'd3, 32'h2);
        applyStimulus(2'd3, 32'h1);
        readReg("t3_w1c_other", 2'd3, 32'h2);
        checkOutput("t3_irq_hold", {31'd0, irq}, 32'h1);
        applyStimulus(2'd3, 32'h2);
        checkOutput("t3_irq_clr", {31'd0, irq}, 32'h0);
        readReg("t3_cap_clr2", 2'd3, 32'h0);

        // 4: falling-edge-only capture on bit2
        applyStimulus(2'd1, 32'h0004_0000);
        applyStimulus(2'd2, 32'h4);
        readReg("t4_cfg", 2'd1, 32'h0004_0000);
        readReg("t4_mask", 2'd2, 32'h4);
        in_port = 4'h7;
        waitCycles(10);
        readReg("t4_rise_data", 2'd0, 32'h7);
        readReg("t4_rise_nocap", 2'd3, 32'h0);
        checkOutput("t4_rise_irq", {31'd0, irq}, 32'h0);
        in_port = 4'h3;
        waitCycles(10);
        readReg("t4_fall_cap", 2'd3, 32'h4);
        checkOutput("t4_fall_irq", {31'd0, irq}, 32'h1);

        // 5: W1C on the very edge a new fall on bit2 debounces
        in_port = 4'h7;
        waitCycles(10);
        readReg("t5_pre_cap", 2'd3, 32'h4);
        in_port = 4'h3;
        waitCycles(5);
        applyStimulus(2'd3, 32'h4);
        readReg("t5_data", 2'd0, 32'h3);
        readReg("t5_cap_kept", 2'd3, 32'h4);
        checkOutput("t5_irq", {31'd0, irq}, 32'h1);

        // 6: reset in the middle of a debounce count
        in_port = 4'hF;
        waitCycles(4);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_readdata", readdata, 32'h0);
        checkOutput("t6_rst_irq", {31'd0, irq}, 32'h0);
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(5);
        readReg("t6_deb_before", 2'd0, 32'h0);
        readReg("t6_deb_after", 2'd0, 32'hF);
        readReg("t6_cap", 2'd3, 32'hF);
        readReg("t6_cfg", 2'd1, 32'h0000_000F);
        readReg("t6_mask", 2'd2, 32'h0);
        checkOutput("t6_irq", {31'd0, irq}, 32'h0);

        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/nios2_c_key_ctrl.md
Name: nios2_c_key_ctrl

Overview:
Avalon-MM slave input controller for the push-key/switch inputs on the Nios II system bus. It sits between raw board inputs and the CPU. Per input bit it:
- synchronises the raw input;
- debounces it with a counter;
- captures selectable rising/falling edges into a sticky write-1-to-clear register;
- raises a level interrupt through a mask.

Parameters:
- WIDTH, 4: number of input bits (1..16).
- DEBOUNCE_CYCLES, 16: consecutive stable clk cycles required before the debounced state changes (>=2). Counter width is clog2(DEBOUNCE_CYCLES).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset. Asserts asynchronously; all state clears immediately.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write requires chipselect=1.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to CPU.

Behaviour:
Register map:
- addr0, DATA (RO): bits [WIDTH-1:0] hold the debounced state.
- addr1, EDGE_CFG (RW): rise_en at bits [WIDTH-1:0]; fall_en at bits [16+WIDTH-1:16].
- addr2, IRQ_MASK (RW): bits [WIDTH-1:0].
- addr3, EDGE_CAP (R/W1C): bits [WIDTH-1:0].
- Unused bits read 0. Writes to addr0 are ignored.

Reset values:
- sync stages, debounced state, counters, fall_en, irq_mask, edge_cap, readdata, irq: all 0.
- rise_en: all ones.

Synchroniser:
- 2-flop chain per bit.
- sync = second stage. A value on in_port at edge E0 appears on sync after edge E1.

Debounce, per bit:
- sync == deb: counter <= 0.
- sync != deb and counter < DEBOUNCE_CYCLES-1: counter increments.
- sync != deb and counter == DEBOUNCE_CYCLES-1: deb <= sync and counter <= 0.
- Net effect: deb changes at edge E1+DEBOUNCE_CYCLES if sync stays stable.
- Any return of sync to deb before that restarts the count from 0.

Edge capture, per bit:
- set = (deb 0->1 at this edge & rise_en) | (deb 1->0 at this edge & fall_en).
- set is evaluated at the same edge that deb updates, so edge_cap bit becomes 1 at that edge.
- Bits are sticky until cleared by writing 1 to that bit at addr3. Writing 0 has no effect.
- Set and W1C clear on the same edge: set wins, bit stays 1.

Config writes:
- Take effect at the next edge.
- A deb transition on the same edge as a config write uses the old config.

irq:
- irq = |(edge_cap & irq_mask), combinational from registers.
- Rises the cycle after edge_cap/irq_mask update.
- Deasserts the cycle after the last set bit is cleared or masked.

Reads:
- readdata registers the addressed word every cycle, independent of chipselect.
- Read latency is 1 cycle; no wait states.

Reset mid-debounce:
- Counters and deb clear; no edge is captured.
- After release, a still-high input needs the full E1+DEBOUNCE_CYCLES delay again and then captures a rising edge if rise_en=1.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset defaults. Drive in_port[0] 0->1 and hold.
   - deb[0]=1 exactly 5 edges after first sample.
   - edge_cap=0x1.
   - irq stays 0 (mask 0).
   - Read addr0 -> 0x1 one cycle after address presented.
2. Glitch rejection: in_port[1] high for 3 cycles then low, DEBOUNCE_CYCLES=4.
   - deb, edge_cap and irq unchanged.
   - Then 0->1 held 10 cycles -> deb[1]=1.
3. Mask/irq: write IRQ_MASK=0x2, then produce a rising edge on bit1.
   - irq=1.
   - Write EDGE_CAP=0x2 -> edge_cap=0, irq=0 next cycle.
   - Write 0x1 instead -> no change.
4. Edge select: write EDGE_CFG=0x00040000 (fall_en[2]=1, rise_en=0), IRQ_MASK=0x4.
   - Bit2 0->1 -> no capture.
   - Bit2 1->0 -> edge_cap=0x4, irq=1.
5. Simultaneous set/clear: issue W1C 0x4 on the exact edge a new fall on bit2 debounces.
   - edge_cap[2]=1 after that edge; irq remains 1.
6. Reset mid-operation: assert reset_n low at debounce count 2 with in_port=0xF.
   - All registers zero asynchronously, rise_en=0xF.
   - After release: deb=0xF and edge_cap=0xF at E1+4.
